// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN,
        SOS
    } state_t;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam int   MAX_FLOORS = 16;

    // True when any pending request lies strictly beyond 'floor' in direction 'dir'.
    function automatic logic calls_ahead(
        input logic [MAX_FLOORS-1:0] led,
        input logic [3:0]            floor,
        input logic                  dir
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (led[i] && ((dir == DIR_UP) ? (i > int'(floor)) : (i < int'(floor)))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/elev_dwell_timer.sv
// Loadable down-counter; expired_o is high whenever the count sits at zero.
// Load takes effect on the next edge; no backpressure.
module elev_dwell_timer #(
    parameter int W = 3
) (
    input  logic         door_clk,
    input  logic         button_reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge door_clk or posedge button_reset) begin
        if (button_reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller; all outputs registered, 1-cycle input-to-output latency.
// Optional DOOR_HOLD_EN adds a door_hold input that extends door dwell like an overload.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS = 4,
    parameter  int MOVE_TICKS = 5,
    parameter  int DOOR_TICKS = 2,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  door_clk,
    input  logic                  button_reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  sos_mode,
    input  logic                  weight_limit_exceeded,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [NUM_FLOORS-1:0] led,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic [FLOOR_W-1:0]    floor_idx,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up
);

    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [MW-1:0] MV_RELOAD = MW'(MOVE_TICKS - 1);
    localparam logic [DW-1:0] DW_RELOAD = DW'(DOOR_TICKS - 1);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d, nxt_floor;
    logic [NUM_FLOORS-1:0]   led_q, led_d, led_set, led_clr;
    logic [NUM_FLOORS-1:0]   onehot_q, onehot_d;
    logic                    dir_q, dir_d;
    logic                    door_q, door_d;
    logic                    moving_q, moving_d;
    logic                    mv_load, dw_load, mv_exp, dw_exp;
    logic                    go_sos, at_floor_call, dwell_hold;

`ifdef DOOR_HOLD_EN
    assign dwell_hold = weight_limit_exceeded | door_hold;
`else
    assign dwell_hold = weight_limit_exceeded;
`endif

    elev_dwell_timer #(.W(MW)) u_travel (
        .door_clk     (door_clk),
        .button_reset (button_reset),
        .load_i       (mv_load),
        .load_val_i   (MV_RELOAD),
        .expired_o    (mv_exp)
    );

    elev_dwell_timer #(.W(DW)) u_dwell (
        .door_clk     (door_clk),
        .button_reset (button_reset),
        .load_i       (dw_load),
        .load_val_i   (DW_RELOAD),
        .expired_o    (dw_exp)
    );

    always_comb begin
        state_d       = state_q;
        floor_d       = floor_q;
        dir_d         = dir_q;
        door_d        = door_q;
        moving_d      = moving_q;
        mv_load       = 1'b0;
        dw_load       = 1'b0;
        go_sos        = 1'b0;
        led_clr       = '0;
        at_floor_call = ~sos_mode & call_btn[floor_q];
        led_set       = sos_mode ? '0 : call_btn;
        // A call at the floor the car is parked on opens the door instead of latching.
        if (state_q == IDLE || state_q == DOOR_OPEN) begin
            led_set[floor_q] = 1'b0;
        end
        nxt_floor = (dir_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (sos_mode) begin
                    go_sos = 1'b1;
                end else if (at_floor_call) begin
                    state_d = DOOR_OPEN;
                    door_d  = 1'b1;
                    dw_load = 1'b1;
                end else if (led_q != '0) begin
                    if (!calls_ahead(MAX_FLOORS'(led_q), 4'(floor_q), dir_q)) begin
                        dir_d = ~dir_q;
                    end
                    state_d  = MOVING;
                    moving_d = 1'b1;
                    mv_load  = 1'b1;
                end
            end
            MOVING: begin
                if (sos_mode) begin
                    go_sos = 1'b1;
                end else if (mv_exp) begin
                    floor_d = nxt_floor;
                    if (led_q[nxt_floor]) begin
                        led_clr[nxt_floor] = 1'b1;
                        state_d  = DOOR_OPEN;
                        moving_d = 1'b0;
                        door_d   = 1'b1;
                        dw_load  = 1'b1;
                    end else if (calls_ahead(MAX_FLOORS'(led_q), 4'(nxt_floor), dir_q)) begin
                        mv_load = 1'b1;
                    end else if (calls_ahead(MAX_FLOORS'(led_q), 4'(nxt_floor), ~dir_q)) begin
                        dir_d   = ~dir_q;
                        mv_load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        moving_d = 1'b0;
                    end
                end
            end
            DOOR_OPEN: begin
                if (dwell_hold || at_floor_call) begin
                    dw_load = 1'b1;
                end else if (dw_exp) begin
                    door_d = 1'b0;
                    if (sos_mode) begin
                        go_sos = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SOS: begin
                if (!sos_mode) begin
                    state_d  = IDLE;
                    door_d   = 1'b0;
                    moving_d = 1'b0;
                end else if (floor_q != '0 && mv_exp) begin
                    floor_d = floor_q - 1'b1;
                    if (floor_q == FLOOR_W'(1)) begin
                        moving_d = 1'b0;
                        door_d   = 1'b1;
                    end else begin
                        mv_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_sos) begin
            state_d  = SOS;
            dir_d    = DIR_DOWN;
            door_d   = (floor_q == '0);
            moving_d = (floor_q != '0);
            mv_load  = (floor_q != '0);
        end

        led_d    = (go_sos || state_q == SOS) ? '0 : ((led_q | led_set) & ~led_clr);
        onehot_d = NUM_FLOORS'(1) << floor_d;
    end

    always_ff @(posedge door_clk or posedge button_reset) begin
        if (button_reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            onehot_q <= NUM_FLOORS'(1);
            led_q    <= '0;
            dir_q    <= DIR_UP;
            door_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            onehot_q <= onehot_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            door_q   <= door_d;
            moving_q <= moving_d;
        end
    end

    assign led          = led_q;
    assign floor_onehot = onehot_q;
    assign floor_idx    = floor_q;
    assign door_open    = door_q;
    assign moving       = moving_q;
    assign dir_up       = dir_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: constant-vector table, directed corner sequences, random vs model.
module tb_elevator_scan_ctrl;

    localparam int NF = 4;
    localparam int MT = 5;
    localparam int DT = 2;
    localparam int FW = 2;

    localparam int M_REST   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DWELL  = 2;
    localparam int M_EMERG  = 3;

    logic          door_clk = 1'b0;
    logic          button_reset;
    logic [NF-1:0] call_btn;
    logic          sos_mode;
    logic          weight_limit_exceeded;
    logic          door_hold;
    logic [NF-1:0] led, floor_onehot;
    logic [FW-1:0] floor_idx;
    logic          door_open, moving, dir_up;

    int n_chk, n_fail;

    int            m_fl, m_mode, m_step_left, m_door_left;
    bit            m_up, m_door, m_mov;
    logic [NF-1:0] m_pend;

    typedef struct {
        int            rep;
        logic [NF-1:0] c;
        logic          s;
        logic          w;
        logic [NF-1:0] e_led;
        int            e_fl;
        logic          e_door;
        logic          e_mov;
        logic          e_dir;
    } vec_t;

    vec_t tbl[$];
    int   stops[$];
    int   dirs[$];
    bit   prev, got, mov_seen, sos_r;
    int   door_cnt;
    logic [NF-1:0] rc;

    always #5 door_clk = ~door_clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS (NF),
        .MOVE_TICKS (MT),
        .DOOR_TICKS (DT)
    ) dut (
        .door_clk              (door_clk),
        .button_reset          (button_reset),
        .call_btn              (call_btn),
        .sos_mode              (sos_mode),
        .weight_limit_exceeded (weight_limit_exceeded),
`ifdef DOOR_HOLD_EN
        .door_hold             (door_hold),
`endif
        .led                   (led),
        .floor_onehot          (floor_onehot),
        .floor_idx             (floor_idx),
        .door_open             (door_open),
        .moving                (moving),
        .dir_up                (dir_up)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit ahead(input logic [NF-1:0] p, input int f, input bit up);
        for (int i = 0; i < NF; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_fl = 0; m_mode = M_REST; m_step_left = 0; m_door_left = 0;
        m_up = 1'b1; m_door = 1'b0; m_mov = 1'b0; m_pend = '0;
    endtask

    task automatic enter_emerg();
        m_mode = M_EMERG;
        m_up   = 1'b0;
        m_pend = '0;
        if (m_fl == 0) begin
            m_door = 1'b1; m_mov = 1'b0;
        end else begin
            m_door = 1'b0; m_mov = 1'b1; m_step_left = MT;
        end
    endtask

    // One clock of the reference: pending set, then travel/dwell bookkeeping in cycles remaining.
    task automatic model_step(input logic [NF-1:0] c, input logic s, input logic w, input logic h);
        logic [NF-1:0] old;
        bit hold_on;
        old = m_pend;
        hold_on = w;
`ifdef DOOR_HOLD_EN
        hold_on = w | h;
`else
        if (h) hold_on = hold_on;
`endif
        if (!s) begin
            for (int i = 0; i < NF; i++) begin
                if (c[i] && !((m_mode == M_REST || m_mode == M_DWELL) && i == m_fl)) m_pend[i] = 1'b1;
            end
        end
        case (m_mode)
            M_REST: begin
                if (s) enter_emerg();
                else if (c[m_fl]) begin
                    m_mode = M_DWELL; m_door_left = DT; m_door = 1'b1;
                end else if (old != '0) begin
                    if (!ahead(old, m_fl, m_up)) m_up = !m_up;
                    m_mode = M_TRAVEL; m_step_left = MT; m_mov = 1'b1;
                end
            end
            M_TRAVEL: begin
                if (s) enter_emerg();
                else begin
                    m_step_left--;
                    if (m_step_left == 0) begin
                        m_fl += m_up ? 1 : -1;
                        if (old[m_fl]) begin
                            m_pend[m_fl] = 1'b0;
                            m_mode = M_DWELL; m_door_left = DT; m_door = 1'b1; m_mov = 1'b0;
                        end else if (ahead(old, m_fl, m_up)) begin
                            m_step_left = MT;
                        end else if (ahead(old, m_fl, !m_up)) begin
                            m_up = !m_up; m_step_left = MT;
                        end else begin
                            m_mode = M_REST; m_mov = 1'b0;
                        end
                    end
                end
            end
            M_DWELL: begin
                if (hold_on || (c[m_fl] && !s)) m_door_left = DT;
                else begin
                    m_door_left--;
                    if (m_door_left == 0) begin
                        m_door = 1'b0;
                        if (s) enter_emerg();
                        else m_mode = M_REST;
                    end
                end
            end
            default: begin
                m_pend = '0;
                if (!s) begin
                    m_mode = M_REST; m_door = 1'b0; m_mov = 1'b0;
                end else if (m_fl != 0) begin
                    m_step_left--;
                    if (m_step_left == 0) begin
                        m_fl--;
                        if (m_fl == 0) begin
                            m_mov = 1'b0; m_door = 1'b1;
                        end else begin
                            m_step_left = MT;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("led", led, m_pend);
        chk("floor_idx", floor_idx, m_fl);
        chk("floor_onehot", floor_onehot, 1 << m_fl);
        chk("door_open", door_open, m_door);
        chk("moving", moving, m_mov);
        chk("dir_up", dir_up, m_up);
    endtask

    task automatic tick(input logic [NF-1:0] c, input logic s, input logic w, input logic h);
        call_btn = c; sos_mode = s; weight_limit_exceeded = w; door_hold = h;
        @(posedge door_clk);
        model_step(c, s, w, h);
        @(negedge door_clk);
        check_model();
    endtask

    task automatic do_reset();
        call_btn = '0; sos_mode = 1'b0; weight_limit_exceeded = 1'b0; door_hold = 1'b0;
        button_reset = 1'b1;
        @(negedge door_clk);
        @(negedge door_clk);
        button_reset = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input int rep, input logic [NF-1:0] c, input logic s, input logic w,
                                input logic [NF-1:0] e_led, input int e_fl, input logic e_door,
                                input logic e_mov, input logic e_dir);
        vec_t v;
        v.rep = rep; v.c = c; v.s = s; v.w = w; v.e_led = e_led; v.e_fl = e_fl;
        v.e_door = e_door; v.e_mov = e_mov; v.e_dir = e_dir;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;

        // Trip 0 -> 3, at-floor call while idle, then call 0 forcing a reversal.
        tbl.push_back(mk(1, 4'b1000, 0, 0, 4'b1000, 0, 0, 0, 1));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b1000, 0, 0, 1, 1));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b1000, 1, 0, 1, 1));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b1000, 2, 0, 1, 1));
        tbl.push_back(mk(2, 4'b0000, 0, 0, 4'b0000, 3, 1, 0, 1));
        tbl.push_back(mk(2, 4'b0000, 0, 0, 4'b0000, 3, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 0, 4'b0000, 3, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 3, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 3, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0001, 0, 0, 4'b0001, 3, 0, 0, 1));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b0001, 3, 0, 1, 0));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b0001, 2, 0, 1, 0));
        tbl.push_back(mk(5, 4'b0000, 0, 0, 4'b0001, 1, 0, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));

        do_reset();
        chk("reset led", led, 0);
        chk("reset floor_idx", floor_idx, 0);
        chk("reset floor_onehot", floor_onehot, 1);
        chk("reset door_open", door_open, 0);
        chk("reset moving", moving, 0);
        chk("reset dir_up", dir_up, 1);

        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                tick(tbl[r].c, tbl[r].s, tbl[r].w, 1'b0);
                chk($sformatf("tbl[%0d] led", r), led, tbl[r].e_led);
                chk($sformatf("tbl[%0d] floor", r), floor_idx, tbl[r].e_fl);
                chk($sformatf("tbl[%0d] door", r), door_open, tbl[r].e_door);
                chk($sformatf("tbl[%0d] moving", r), moving, tbl[r].e_mov);
                chk($sformatf("tbl[%0d] dir", r), dir_up, tbl[r].e_dir);
            end
        end

        // Calls 1 and 3, then 2 during travel: stops 1,2,3 going up.
        do_reset();
        stops.delete(); prev = 1'b0;
        tick(4'b1010, 0, 0, 0);
        for (int k = 0; k < 60; k++) begin
            tick((k == 3) ? 4'b0100 : 4'b0000, 0, 0, 0);
            chk("t2 dir_up", dir_up, 1);
            if (door_open && !prev) stops.push_back(int'(floor_idx));
            prev = door_open;
        end
        chk("t2 stop count", stops.size(), 3);
        for (int k = 0; k < 3; k++) chk("t2 stop order", (k < stops.size()) ? stops[k] : -1, k + 1);

        // Heading up with calls {0,3}: serve 3 first, then reverse to 0.
        do_reset();
        stops.delete(); dirs.delete(); prev = 1'b0;
        tick(4'b1000, 0, 0, 0);
        for (int k = 0; k < 50; k++) begin
            tick((k == 6) ? 4'b0001 : 4'b0000, 0, 0, 0);
            if (door_open && !prev) begin
                stops.push_back(int'(floor_idx));
                dirs.push_back(int'(dir_up));
            end
            prev = door_open;
        end
        chk("t3 stop count", stops.size(), 2);
        chk("t3 first stop", (stops.size() > 0) ? stops[0] : -1, 3);
        chk("t3 first dir", (dirs.size() > 0) ? dirs[0] : -1, 1);
        chk("t3 second stop", (stops.size() > 1) ? stops[1] : -1, 0);
        chk("t3 second dir", (dirs.size() > 1) ? dirs[1] : -1, 0);

        // Overload for 6 cycles at floor 1 holds the door for 8 cycles with a call pending.
        do_reset();
        tick(4'b0010, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(4'b0000, 0, 0, 0);
            if (door_open) got = 1'b1;
        end
        chk("t4 door reached", got, 1);
        door_cnt = 1; mov_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick((k == 0) ? 4'b1000 : 4'b0000, 0, 1, 0);
            if (door_open) door_cnt++;
            if (moving) mov_seen = 1'b1;
        end
        for (int k = 0; k < 20 && door_open; k++) begin
            tick(4'b0000, 0, 0, 0);
            if (door_open) door_cnt++;
            if (moving && door_open) mov_seen = 1'b1;
        end
        chk("t4 door cycles", door_cnt, 8);
        chk("t4 no move", mov_seen, 0);
        chk("t4 floor", floor_idx, 1);
        chk("t4 pending", led, 4'b1000);

        // SOS while travelling 2 -> 3: requests dropped, descend to 0, door held.
        do_reset();
        tick(4'b1000, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick(4'b0000, 0, 0, 0);
            if (floor_idx == 2) got = 1'b1;
        end
        chk("t5 reach floor 2", got, 1);
        tick(4'b0000, 0, 0, 0);
        tick(4'b0000, 1, 0, 0);
        chk("t5 led cleared", led, 0);
        chk("t5 dir down", dir_up, 0);
        chk("t5 moving", moving, 1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick(4'b0000, 1, 0, 0);
            if (door_open) got = 1'b1;
        end
        chk("t5 door at bottom", got, 1);
        chk("t5 floor 0", floor_idx, 0);
        for (int k = 0; k < 3; k++) begin
            tick(4'b0110, 1, 0, 0);
            chk("t5 door held", door_open, 1);
            chk("t5 calls ignored", led, 0);
        end
        tick(4'b0000, 0, 0, 0);
        chk("t5 exit door", door_open, 0);
        chk("t5 exit moving", moving, 0);

        // Asynchronous reset mid-step at floor 2.
        do_reset();
        tick(4'b1000, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick(4'b0000, 0, 0, 0);
            if (floor_idx == 2) got = 1'b1;
        end
        chk("t6 reach floor 2", got, 1);
        tick(4'b0000, 0, 0, 0);
        #2 button_reset = 1'b1;
        #1;
        chk("t6 async floor", floor_idx, 0);
        chk("t6 async moving", moving, 0);
        chk("t6 async led", led, 0);
        chk("t6 async onehot", floor_onehot, 1);
        @(posedge door_clk);
        #1;
        chk("t6 next floor", floor_idx, 0);
        chk("t6 next moving", moving, 0);
        chk("t6 next dir", dir_up, 1);
        @(negedge door_clk);
        button_reset = 1'b0;
        model_reset();
        tick(4'b0000, 0, 0, 0);

        // Random traffic with occasional SOS episodes, overloads and holds.
        do_reset();
        sos_r = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 59) == 0) sos_r = !sos_r;
            for (int i = 0; i < NF; i++) rc[i] = ($urandom_range(0, 9) == 0);
            tick(rc, sos_r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
